// File: rtl/typed_chan_fifo_arb_if.sv
// Handshake bundle for typed_chan_fifo_arb: NUM_CH typed producer channels,
// one shared consumer port, per-channel flush and occupancy.
interface typed_chan_fifo_arb_if #(
  parameter type         T      = logic [31:0],
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH-1:0]         in_ready;
  T                          in_data [NUM_CH];
  logic [NUM_CH-1:0]         flush;
  logic                      out_valid;
  logic                      out_ready;
  T                          out_data;
  logic [CW-1:0]             out_ch;
  logic [NUM_CH-1:0][LW-1:0] level;

  // producer/consumer side
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ch, level
  );

  // buffer side
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_ch, level
  );
endinterface

// File: rtl/typed_chan_fifo_arb.sv
// Multi-channel typed FIFO buffer with round-robin merge onto one registered
// output tagged with the source channel. Each channel owns a DEPTH-entry
// circular buffer addressed by LW-bit pointers whose MSB is the wrap bit.
module typed_chan_fifo_arb #(
  parameter type         T      = logic [31:0],
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  typed_chan_fifo_arb_if.slave bus
);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = LW - 1;

  logic [LW-1:0]     wr_q [NUM_CH];
  logic [LW-1:0]     wr_d [NUM_CH];
  logic [LW-1:0]     rd_q [NUM_CH];
  logic [LW-1:0]     rd_d [NUM_CH];
  T                  mem_q [NUM_CH][DEPTH];
  T                  mem_d [NUM_CH][DEPTH];

  logic              out_valid_q, out_valid_d;
  T                  out_data_q, out_data_d;
  logic [CW-1:0]     out_ch_q, out_ch_d;
  logic [CW-1:0]     last_grant_q, last_grant_d;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] in_ready;
  logic [CW-1:0]     grant;
  logic              any_elig;
  logic              load;
  int unsigned       idx;

  // Per-channel status: full/empty from pointers, accept and eligibility.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      empty[i]     = (wr_q[i] == rd_q[i]);
      full[i]      = (wr_q[i][IW-1:0] == rd_q[i][IW-1:0]) && (wr_q[i][IW] != rd_q[i][IW]);
      in_ready[i]  = rst_n & ~full[i] & ~bus.flush[i];
      push[i]      = bus.in_valid[i] & in_ready[i];
      eligible[i]  = ~empty[i] & ~bus.flush[i];
      bus.level[i] = wr_q[i] - rd_q[i];
    end
  end

  assign bus.in_ready = in_ready;

  // Round-robin pick: first eligible channel strictly after last_grant.
  always_comb begin
    grant    = '0;
    any_elig = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(last_grant_q) + k) % NUM_CH;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        grant    = CW'(idx);
      end
    end
  end

  assign load = (~out_valid_q | bus.out_ready) & any_elig;

  // Pointer advance, flush and output-register next state.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_d[i] = push[i] ? wr_q[i] + LW'(1) : wr_q[i];
      rd_d[i] = rd_q[i];
      // A flushed channel is never eligible, so flush and pop cannot collide.
      if (bus.flush[i]) begin
        rd_d[i] = wr_q[i];
      end else if (load && (grant == CW'(i))) begin
        rd_d[i] = rd_q[i] + LW'(1);
      end
    end
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = mem_q[grant][rd_q[grant][IW-1:0]];
      out_ch_d     = grant;
      last_grant_d = grant;
    end else if (~out_valid_q | bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage write for accepted entries.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        mem_d[i][wr_q[i][IW-1:0]] = bus.in_data[i];
      end
    end
  end

  // Entry storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointers and output register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_q[i] <= '0;
        rd_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= CW'(NUM_CH - 1);
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule
